// File: rtl/mult_issue_pkg.sv
// Shared types for the multiplier issue stage: FSM states, buffer entry, counter width.
package mult_issue_pkg;

    localparam int unsigned CNT_W = 16;
    // Entry fields are sized for the widest supported operand; narrower
    // instances zero-extend on push and truncate on read.
    localparam int unsigned MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    typedef struct packed {
        logic [MAX_W-1:0] mplr;
        logic [MAX_W-1:0] mplr_t;
        logic [MAX_W-1:0] mcnd;
        logic [MAX_W-1:0] mcnd_t;
        logic             ctl_t;
    } entry_t;

endpackage

// File: rtl/mult_issue_fifo.sv
// Operand buffer: DEPTH-entry FIFO with per-entry control-taint tracking.
module mult_issue_fifo
    import mult_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t head,
    output logic   empty,
    output logic   full_nxt,
    output logic   taint_nxt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;

    entry_t              mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_FW-1:0]   count;
    logic [CNT_FW-1:0]   count_nxt;
    logic [DEPTH-1:0]    taint_q;
    logic [DEPTH-1:0]    taint_d;

    // Occupancy and per-slot taint after this cycle's push/pop.
    // Push and pop never hit the same slot: that needs an empty or full buffer.
    always_comb begin
        count_nxt = count + CNT_FW'(push) - CNT_FW'(pop);
        taint_d   = taint_q;
        if (push) taint_d[wr_ptr] = wdata.ctl_t;
        if (pop)  taint_d[rd_ptr] = 1'b0;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            taint_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_nxt;
            taint_q <= taint_d;
        end
    end

    // Entry storage; contents of empty slots are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head      = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full_nxt  = (count_nxt == CNT_FW'(DEPTH));
    assign taint_nxt = |taint_d;

endmodule

// File: rtl/mult_issue_tainttrack.sv
// Buffers operand pairs and issues them one at a time to a multiplier,
// propagating taint alongside data and control.
// Optional macro MULT_ISSUE_CNT_EN enables the 16-bit completed-operation counter.
module mult_issue_tainttrack
    import mult_issue_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_valid_t,
    input  logic [WIDTH-1:0] in_mplr,
    input  logic [WIDTH-1:0] in_mplr_t,
    input  logic [WIDTH-1:0] in_mcnd,
    input  logic [WIDTH-1:0] in_mcnd_t,
    output logic             in_ready,
    output logic             in_ready_t,
    output logic             start,
    output logic             start_t,
    output logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] multiplier_t,
    output logic [WIDTH-1:0] multiplicand,
    output logic [WIDTH-1:0] multiplicand_t,
    input  logic             productDone,
    input  logic             productDone_t,
    output logic             busy,
    output logic [CNT_W-1:0] issue_cnt
);

    state_t state;
    entry_t wdata;
    entry_t head;
    logic   empty;
    logic   full_nxt;
    logic   taint_nxt;
    logic   push;
    logic   pop;
    logic   done_t;
    logic   done_t_nxt;
    logic   unused_hi;

    assign push = in_valid && in_ready;
    assign pop  = (state == WAIT_HI) && productDone;

    // Pack the offered operands into a buffer entry.
    always_comb begin
        wdata.mplr   = MAX_W'(in_mplr);
        wdata.mplr_t = MAX_W'(in_mplr_t);
        wdata.mcnd   = MAX_W'(in_mcnd);
        wdata.mcnd_t = MAX_W'(in_mcnd_t);
        wdata.ctl_t  = in_valid_t;
    end

    mult_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wdata     (wdata),
        .head      (head),
        .empty     (empty),
        .full_nxt  (full_nxt),
        .taint_nxt (taint_nxt)
    );

    // Sticky completion taint: set while waiting on the multiplier, cleared on pop.
    always_comb begin
        done_t_nxt = done_t;
        if (((state == WAIT_LO) || (state == WAIT_HI)) && productDone_t) done_t_nxt = 1'b1;
        if (pop) done_t_nxt = 1'b0;
    end

    // Issue FSM with registered start/start_t/busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            start   <= 1'b0;
            start_t <= 1'b0;
            busy    <= 1'b0;
        end else begin
            start   <= 1'b0;
            start_t <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= START;
                        start   <= 1'b1;
                        start_t <= head.ctl_t;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT_LO;
                end
                WAIT_LO: begin
                    // A done level left over from the previous op must drop first.
                    if (!productDone) state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (productDone) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand outputs track the buffer head; zero while the buffer is empty.
    always_ff @(posedge clk) begin
        if (rst || empty) begin
            multiplier     <= '0;
            multiplier_t   <= '0;
            multiplicand   <= '0;
            multiplicand_t <= '0;
        end else begin
            multiplier     <= WIDTH'(head.mplr);
            multiplier_t   <= WIDTH'(head.mplr_t);
            multiplicand   <= WIDTH'(head.mcnd);
            multiplicand_t <= WIDTH'(head.mcnd_t);
        end
    end

    // Ready and its taint are registered from next-cycle buffer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b1;
            in_ready_t <= 1'b0;
            done_t     <= 1'b0;
        end else begin
            in_ready   <= !full_nxt;
            in_ready_t <= taint_nxt | done_t_nxt;
            done_t     <= done_t_nxt;
        end
    end

`ifdef MULT_ISSUE_CNT_EN
    // Completed-operation counter, wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (rst)      issue_cnt <= '0;
        else if (pop) issue_cnt <= issue_cnt + CNT_W'(1);
    end
`else
    assign issue_cnt = '0;
`endif

    // Entry bits above WIDTH are always zero and intentionally unused.
    assign unused_hi = ^{head.mplr, head.mplr_t, head.mcnd, head.mcnd_t};

endmodule
